// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host byte stream to instruction ROM loader.
// Holds the CPU in reset until a full image with a matching XOR checksum is written.
module prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [1:0]          b_q, b_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          acc_q, acc_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic                rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   rom_wdata_q, rom_wdata_d;
    logic                accept;
    logic [16:0]         n_full;

    assign rx_ready  = (state_q == S_IDLE) || (state_q == S_CNT_HI) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept    = rx_valid && rx_ready;
    assign done      = (state_q == S_DONE);
    assign cpu_run   = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign word_cnt  = word_cnt_q;
    assign n_full    = {1'b0, rx_data, n_q[7:0]};

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        b_d         = b_q;
        asm_d       = asm_q;
        acc_d       = acc_q;
        word_cnt_d  = word_cnt_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    n_d[7:0] = rx_data;
                    state_d  = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    n_d[15:8] = rx_data;
                    b_d       = 2'd0;
                    if (n_full > MAX_N) begin
                        state_d = S_ERR;
                    end else if (n_full == 17'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    acc_d = acc_q ^ rx_data;
                    b_d   = b_q + 2'd1;
                    case (b_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            // Word goes to its own register so byte 0 of the next word can land in asm_q meanwhile.
                            rom_we_d    = 1'b1;
                            rom_addr_d  = word_cnt_q[ADDR_W-1:0];
                            rom_wdata_d = {rx_data, asm_q};
                            word_cnt_d  = word_cnt_q + (ADDR_W+1)'(1);
                            if (17'(word_cnt_q) + 17'd1 == {1'b0, n_q}) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == acc_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d    = S_IDLE;
                    word_cnt_d = '0;
                    acc_d      = 8'd0;
                    n_d        = 16'd0;
                    b_d        = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= 16'd0;
            b_q         <= 2'd0;
            asm_q       <= 24'd0;
            acc_q       <= 8'd0;
            word_cnt_q  <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            b_q         <= b_d;
            asm_q       <= asm_d;
            acc_q       <= acc_d;
            word_cnt_q  <= word_cnt_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
        end
    end

endmodule
